// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM state type for the SPI configuration target.
package spi_cfg_pkg;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  localparam int FRAME_BITS = 16;
  // Bit counter stops here so overlong frames still read as "not 16"
  localparam logic [4:0] CNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a history flop
// so rise/fall pulses come from the last two stages.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      hist <= RESET_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target holding the PWM block's configuration registers.
module spi_peripheral
  import spi_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic unused_edges;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .pin(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .pin(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .pin(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  assign unused_edges = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

  state_t      state, next_state;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [7:0]  regs [NUM_REGS];
  logic [6:0]  addr;
  logic        frame_ok, addr_ok, do_write, do_err;

  assign addr     = shreg[14:8];
  assign frame_ok = (bit_cnt == 5'(FRAME_BITS));
  assign addr_ok  = (32'(addr) < NUM_REGS);

  always_comb begin
    next_state = state;
    do_write   = 1'b0;
    do_err     = 1'b0;
    case (state)
      IDLE:   if (ncs_fall) next_state = SHIFT;
      SHIFT:  if (ncs_rise) next_state = COMMIT;
      COMMIT: begin
        next_state = IDLE;
        if (!frame_ok)                 do_err   = 1'b1;
        else if (shreg[15] && addr_ok) do_write = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state     <= next_state;
      wr_strobe <= do_write;
      frame_err <= do_err;
      if (state == IDLE && ncs_fall) bit_cnt <= '0;
      if (state == SHIFT && sclk_rise && !ncs_level) begin
        shreg <= {shreg[14:0], copi_level};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
      end
      if (do_write) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (addr == 7'(i)) regs[i] <= shreg[7:0];
      end
    end
  end

  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed frame table, reset
// mid-frame, then randomised back-to-back frames against a register model.
module tb_spi_peripheral;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_REGS    = 5;
  localparam int HALF        = 3;
  localparam int SETUP       = SYNC_STAGES + 2;
  localparam int GAP         = SYNC_STAGES + 3;
  localparam int LATENCY     = SYNC_STAGES + 2;

  logic       clk, rst, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int strobe_cyc = 0;
  int rise_cyc = 0;
  logic [7:0] model [NUM_REGS];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse widths are counted in cycles so a stretched pulse shows up as extra
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_cyc = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_strobes;
    int          exp_errs;
  } vec_t;

  vec_t vecs [9];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [39:0] dutRegs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] modelRegs();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  // Host side: nbits of 'bits' MSB first, optionally closing the frame
  task automatic applyStimulus(input logic [31:0] bits, input int nbits, input bit close);
    ncs  = 1'b0;
    sclk = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      tick((i == nbits - 1) ? SETUP : HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    if (close) begin
      ncs      = 1'b1;
      rise_cyc = cyc;
    end
  endtask

  task automatic modelFrame(input logic [15:0] frame, input int nbits,
                            output int exp_s, output int exp_e);
    int a;
    a     = int'(frame[14:8]);
    exp_s = 0;
    exp_e = 0;
    if (nbits != 16) exp_e = 1;
    else if (frame[15] && a < NUM_REGS) begin
      model[a] = frame[7:0];
      exp_s    = 1;
    end
  endtask

  task automatic runFrame(input logic [31:0] bits, input int nbits,
                          output int got_s, output int got_e);
    int s0, e0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    applyStimulus(bits, nbits, 1'b1);
    tick(GAP);
    got_s = strobe_cnt - s0;
    got_e = err_cnt - e0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int gs, ge, es, ee;
    logic [15:0] f16;
    logic [31:0] bits;
    int nb;

    vecs[0] = '{32'h8480,  16, 40'h80_00_00_00_00, 1, 0};
    vecs[1] = '{32'h80FF,  16, 40'h80_00_00_00_FF, 1, 0};
    vecs[2] = '{32'h810F,  16, 40'h80_00_00_0F_FF, 1, 0};
    vecs[3] = '{32'h82AA,  16, 40'h80_00_AA_0F_FF, 1, 0};
    vecs[4] = '{32'h8355,  16, 40'h80_55_AA_0F_FF, 1, 0};
    vecs[5] = '{32'h0433,  16, 40'h80_55_AA_0F_FF, 0, 0};
    vecs[6] = '{32'h8533,  16, 40'h80_55_AA_0F_FF, 0, 0};
    vecs[7] = '{32'h4208,  15, 40'h80_55_AA_0F_FF, 0, 1};
    vecs[8] = '{32'h10823, 17, 40'h80_55_AA_0F_FF, 0, 1};

    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    tick(2);
    checkOutput("reset_regs", dutRegs(), 40'h0);
    checkOutput("reset_wr_strobe", wr_strobe, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    tick(2);

    for (int v = 0; v < 9; v++) begin
      runFrame(vecs[v].bits, vecs[v].nbits, gs, ge);
      modelFrame(vecs[v].bits[15:0], vecs[v].nbits, es, ee);
      checkOutput($sformatf("vec%0d_regs", v), dutRegs(), vecs[v].exp_regs);
      checkOutput($sformatf("vec%0d_strobes", v), gs, vecs[v].exp_strobes);
      checkOutput($sformatf("vec%0d_errs", v), ge, vecs[v].exp_errs);
      if (vecs[v].exp_strobes == 1)
        checkOutput($sformatf("vec%0d_latency", v), strobe_cyc - rise_cyc, LATENCY);
    end

    // Reset lands after the first byte of 0x84C0 while nCS is still low
    applyStimulus(32'h0084, 8, 1'b0);
    rst = 1'b1;
    tick(2);
    checkOutput("midreset_regs", dutRegs(), 40'h0);
    checkOutput("midreset_wr_strobe", wr_strobe, 1'b0);
    checkOutput("midreset_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    ncs = 1'b1;
    tick(GAP + 3);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    runFrame(32'h84C0, 16, gs, ge);
    modelFrame(16'h84C0, 16, es, ee);
    checkOutput("after_reset_regs", dutRegs(), 40'hC0_00_00_00_00);
    checkOutput("after_reset_strobes", gs, 1);
    checkOutput("after_reset_latency", strobe_cyc - rise_cyc, LATENCY);

    // Random frames at minimum SCLK phases and minimum nCS high time
    for (int n = 0; n < 24; n++) begin
      int k;
      f16 = {1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
      k   = $urandom_range(0, 7);
      if (k == 0) begin
        nb   = 15;
        bits = {17'h0, f16[15:1]};
      end else if (k == 1) begin
        nb   = 17;
        bits = {15'h0, f16, 1'($urandom)};
      end else begin
        nb   = 16;
        bits = {16'h0, f16};
      end
      runFrame(bits, nb, gs, ge);
      modelFrame(f16, nb, es, ee);
      checkOutput($sformatf("rand%0d_regs", n), dutRegs(), modelRegs());
      checkOutput($sformatf("rand%0d_strobes", n), gs, es);
      checkOutput($sformatf("rand%0d_errs", n), ge, ee);
      if (es == 1)
        checkOutput($sformatf("rand%0d_latency", n), strobe_cyc - rise_cyc, LATENCY);
    end

    tick(4);
    checkOutput("final_idle_strobe", wr_strobe, 1'b0);
    checkOutput("final_idle_err", frame_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
